// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority; a streak counter bounds how long a waiting fetch can be passed over.
module mem_port_arbiter #(
   parameter int unsigned LAT         = 2,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   output logic        IReady,
   output logic [31:0] IRData,
   input  logic        DReq,
   input  logic        DWE,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWData,
   output logic        DReady,
   output logic [31:0] DRData,
   output logic        MemEN,
   output logic        MemWE,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData
);

   localparam int unsigned CntW    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int unsigned StreakW = $clog2(MAX_DSTREAK + 1);

   localparam logic [CntW-1:0]    CntLoad   = CntW'(LAT - 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DSTREAK);

   typedef enum logic [1:0] {
      StIdle,
      StIacc,
      StDacc
   } state_e;

   state_e               state;
   logic [CntW-1:0]      cnt;
   logic [StreakW-1:0]   dstreak;

   logic i_elig;
   logic d_elig;
   logic grant_d;
   logic grant_i;

   // A requester whose Ready is high this cycle is still holding its old request.
   assign i_elig  = IReq & ~IReady;
   assign d_elig  = DReq & ~DReady;
   assign grant_d = d_elig & (~i_elig | (dstreak != StreakMax));
   assign grant_i = i_elig & ~grant_d;

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state    <= StIdle;
         cnt      <= '0;
         dstreak  <= '0;
         IReady   <= 1'b0;
         IRData   <= '0;
         DReady   <= 1'b0;
         DRData   <= '0;
         MemEN    <= 1'b0;
         MemWE    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
      end else begin
         IReady <= 1'b0;
         DReady <= 1'b0;
         unique case (state)
            StIdle: begin
               if (grant_d) begin
                  state    <= StDacc;
                  cnt      <= CntLoad;
                  MemEN    <= 1'b1;
                  MemWE    <= DWE;
                  MemAddr  <= DAddr;
                  MemWData <= DWData;
                  if (!IReq) begin
                     dstreak <= '0;
                  end else if (dstreak != StreakMax) begin
                     dstreak <= dstreak + 1'b1;
                  end
               end else if (grant_i) begin
                  state    <= StIacc;
                  cnt      <= CntLoad;
                  MemEN    <= 1'b1;
                  MemWE    <= 1'b0;
                  MemAddr  <= IAddr;
                  MemWData <= '0;
                  dstreak  <= '0;
               end
            end
            StIacc, StDacc: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  // Last access cycle: MemRData is valid now.
                  if (state == StIacc) begin
                     IRData <= MemRData;
                     IReady <= 1'b1;
                  end else begin
                     if (!MemWE) begin
                        DRData <= MemRData;
                     end
                     DReady <= 1'b1;
                  end
                  state    <= StIdle;
                  MemEN    <= 1'b0;
                  MemWE    <= 1'b0;
                  MemAddr  <= '0;
                  MemWData <= '0;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LAT=2, MAX_DSTREAK=4) with hand-computed expectations.
module tb_mem_port_arbiter;

   logic        CLOCK;
   logic        RESET;
   logic        IReq;
   logic [31:0] IAddr;
   logic        IReady;
   logic [31:0] IRData;
   logic        DReq;
   logic        DWE;
   logic [31:0] DAddr;
   logic [31:0] DWData;
   logic        DReady;
   logic [31:0] DRData;
   logic        MemEN;
   logic        MemWE;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(
      .LAT         (2),
      .MAX_DSTREAK (4)
   ) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .IReq     (IReq),
      .IAddr    (IAddr),
      .IReady   (IReady),
      .IRData   (IRData),
      .DReq     (DReq),
      .DWE      (DWE),
      .DAddr    (DAddr),
      .DWData   (DWData),
      .DReady   (DReady),
      .DRData   (DRData),
      .MemEN    (MemEN),
      .MemWE    (MemWE),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemRData (MemRData)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET    = 1'b0;
      IReq     = 1'b1;
      DReq     = 1'b1;
      IAddr    = 32'h0000_0100;
      DAddr    = 32'h0000_0200;
      DWE      = 1'b0;
      DWData   = 32'h0000_0055;
      MemRData = 32'h0;

      // Reset held two edges with both requests high.
      tick();
      tick();
      chk("rst_memen",    {31'd0, MemEN},  32'd0);
      chk("rst_memwe",    {31'd0, MemWE},  32'd0);
      chk("rst_memaddr",  MemAddr,         32'd0);
      chk("rst_memwdata", MemWData,        32'd0);
      chk("rst_iready",   {31'd0, IReady}, 32'd0);
      chk("rst_dready",   {31'd0, DReady}, 32'd0);
      chk("rst_irdata",   IRData,          32'd0);
      chk("rst_drdata",   DRData,          32'd0);

      // Release: both pending -> data wins first.
      RESET = 1'b1;
      tick();
      chk("a_memen_k1",   {31'd0, MemEN},  32'd1);
      chk("a_addr_d",     MemAddr,         32'h0000_0200);
      chk("a_memwe_rd",   {31'd0, MemWE},  32'd0);
      chk("a_wdata_d",    MemWData,        32'h0000_0055);
      MemRData = 32'hA5A5_0001;
      tick();
      chk("a_memen_k2",   {31'd0, MemEN},  32'd1);
      chk("a_dready_k2",  {31'd0, DReady}, 32'd0);
      tick();
      chk("a_dready_k3",  {31'd0, DReady}, 32'd1);
      chk("a_drdata",     DRData,          32'hA5A5_0001);
      chk("a_memen_k3",   {31'd0, MemEN},  32'd0);
      chk("a_iready_k3",  {31'd0, IReady}, 32'd0);
      DReq = 1'b0;

      // Ready cycle arbitrates the waiting fetch.
      tick();
      chk("a_memen_k4",   {31'd0, MemEN},  32'd1);
      chk("a_addr_i",     MemAddr,         32'h0000_0100);
      chk("a_wdata_i",    MemWData,        32'd0);
      chk("a_memwe_i",    {31'd0, MemWE},  32'd0);
      MemRData = 32'hDEAD_BEEF;
      tick();
      chk("a_memen_k5",   {31'd0, MemEN},  32'd1);
      chk("a_iready_k5",  {31'd0, IReady}, 32'd0);
      tick();
      chk("a_iready_k6",  {31'd0, IReady}, 32'd1);
      chk("a_irdata",     IRData,          32'hDEAD_BEEF);
      chk("a_drdata_keep", DRData,         32'hA5A5_0001);
      IReq = 1'b0;
      tick();
      chk("a_iready_off", {31'd0, IReady}, 32'd0);
      chk("a_idle_memen", {31'd0, MemEN},  32'd0);
      chk("a_irdata_hold", IRData,         32'hDEAD_BEEF);

      // Data write.
      DReq     = 1'b1;
      DWE      = 1'b1;
      DAddr    = 32'h0000_0020;
      DWData   = 32'h1234_5678;
      MemRData = 32'hFFFF_0000;
      tick();
      chk("w_memwe_k1",   {31'd0, MemWE},  32'd1);
      chk("w_wdata",      MemWData,        32'h1234_5678);
      chk("w_addr",       MemAddr,         32'h0000_0020);
      tick();
      chk("w_memwe_k2",   {31'd0, MemWE},  32'd1);
      chk("w_dready_k2",  {31'd0, DReady}, 32'd0);
      tick();
      chk("w_dready_k3",  {31'd0, DReady}, 32'd1);
      chk("w_drdata_keep", DRData,         32'hA5A5_0001);
      chk("w_memwe_off",  {31'd0, MemWE},  32'd0);
      chk("w_wdata_clr",  MemWData,        32'd0);
      chk("w_addr_clr",   MemAddr,         32'd0);
      DReq = 1'b0;
      tick();

      // Reset during a data write aborts it; held request is re-served.
      DReq  = 1'b1;
      DWE   = 1'b1;
      DAddr = 32'h0000_0040;
      tick();
      chk("r_memen_k1",   {31'd0, MemEN},  32'd1);
      RESET = 1'b0;
      tick();
      chk("r_memen_k2",   {31'd0, MemEN},  32'd0);
      chk("r_memwe_k2",   {31'd0, MemWE},  32'd0);
      chk("r_dready_k2",  {31'd0, DReady}, 32'd0);
      chk("r_drdata_clr", DRData,          32'd0);
      chk("r_irdata_clr", IRData,          32'd0);
      RESET = 1'b1;
      tick();
      chk("r_reserve_en", {31'd0, MemEN},  32'd1);
      chk("r_reserve_ad", MemAddr,         32'h0000_0040);
      chk("r_dready_k3",  {31'd0, DReady}, 32'd0);
      tick();
      tick();
      chk("r_dready",     {31'd0, DReady}, 32'd1);
      chk("r_drdata_wr",  DRData,          32'd0);
      DReq = 1'b0;
      DWE  = 1'b0;
      tick();
      chk("r_idle",       {31'd0, MemEN},  32'd0);

      // Streak bound: fetch dips only in each data Ready cycle, so both are
      // eligible at every following grant; four data grants, then fetch.
      IAddr    = 32'h0000_0300;
      DAddr    = 32'h0000_0400;
      MemRData = 32'h0BAD_F00D;
      IReq     = 1'b1;
      DReq     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("s_dgrant%0d", i), MemAddr, 32'h0000_0400);
         tick();
         tick();
         chk($sformatf("s_dready%0d", i), {31'd0, DReady}, 32'd1);
         IReq = 1'b0;
         tick();
         chk($sformatf("s_gap%0d", i), {31'd0, MemEN}, 32'd0);
         IReq = 1'b1;
      end
      tick();
      chk("s_igrant",     MemAddr,         32'h0000_0300);
      chk("s_igrant_en",  {31'd0, MemEN},  32'd1);
      tick();
      tick();
      chk("s_iready",     {31'd0, IReady}, 32'd1);
      chk("s_irdata",     IRData,          32'h0BAD_F00D);
      tick();
      chk("s_dagain",     MemAddr,         32'h0000_0400);
      IReq = 1'b0;
      tick();
      tick();
      chk("s_dready_end", {31'd0, DReady}, 32'd1);
      DReq = 1'b0;
      tick();
      chk("s_final_idle", {31'd0, MemEN},  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-port main memory between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage). It serializes accesses, holds each memory command stable for a fixed access latency, and returns read data with a one-cycle ready pulse. The pipeline uses the inverted ready signals as stall sources. Data accesses have priority, and a streak limit bounds instruction-fetch starvation.

## Interface
- LAT, 2: memory access latency in cycles, >= 1.
- MAX_DSTREAK, 4: maximum consecutive data grants while an instruction request waits, >= 1.
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low reset.
- IReq  in  1  instruction-fetch request. Held high until IReady.
- IAddr  in  32  fetch address. Stable while IReq is high.
- IReady  out  1  one-cycle pulse when the fetch completes.
- IRData  out  32  fetched word. Valid while IReady is high; holds its value otherwise.
- DReq  in  1  data request. Held high until DReady.
- DWE  in  1  1 = write, 0 = read. Stable while DReq is high.
- DAddr  in  32  data address.
- DWData  in  32  write data.
- DReady  out  1  one-cycle pulse when the data access completes.
- DRData  out  32  read data. Updated only on reads.
- MemEN  out  1  memory command valid.
- MemWE  out  1  memory write enable.
- MemAddr  out  32  memory address.
- MemWData  out  32  memory write data.
- MemRData  in  32  memory read data. Valid in the last cycle of an access.

## Operation
- States: IDLE, IACC, DACC. Counter cnt, width clog2(LAT) or 1, whichever is larger.
- Eligibility: a requester is ineligible in the cycle its own Ready is high. Its request counts as new from the following cycle.
- In IDLE, arbitration at each rising edge:
  - If only one requester is eligible, grant that requester.
  - If both are eligible, grant DACC, unless dstreak == MAX_DSTREAK, in which case grant IACC.
  - If neither is eligible, stay in IDLE.
- On a grant:
  - State becomes IACC or DACC, and cnt <= LAT-1.
  - MemEN <= 1.
  - MemAddr is loaded with the granted address.
  - MemWE <= DWE & (grant is D).
  - MemWData <= DWData for a D grant, 0 for an I grant.
- In IACC/DACC:
  - Memory outputs are held constant.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: capture MemRData into IRData (IACC) or DRData (DACC read only). Pulse the matching Ready for one cycle. Clear MemEN, MemWE, MemAddr and MemWData to 0. Return to IDLE.
- dstreak register, width clog2(MAX_DSTREAK+1):
  - A D grant with IReq high increments it, saturating at MAX_DSTREAK.
  - A D grant with IReq low clears it to 0.
  - An I grant clears it to 0.
- Arbiter-side stall outputs are not provided. The pipeline derives stall as Req & ~Ready.

## Timing
- Reset (RESET low at an edge):
  - State becomes IDLE; cnt and dstreak become 0.
  - All outputs go to 0, including IRData and DRData.
  - An access in flight is aborted: no Ready pulse, and MemEN/MemWE are low from the next cycle.
- Access latency: a request first sampled at edge k produces:
  - MemEN high in cycles k+1 .. k+LAT;
  - Ready high in cycle k+LAT+1.
- Back-to-back accesses: the Ready cycle is spent in IDLE and arbitrates the other requester. Minimum spacing is LAT+1 cycles per access.
- Simultaneous new requests in IDLE are resolved by the priority and streak rule only. No combinational path exists from any input to any output.
- Write access: DReady pulses with the same latency as a read. DRData is unchanged.
- A request deasserted before its Ready is a protocol violation. The access completes regardless.

## Test plan
- Reset: hold RESET=0 for 2 cycles with IReq=DReq=1 -> all outputs 0, no MemEN. After releasing reset, the first MemEN appears one cycle later.
- Fetch read (LAT=2): IReq=1, IAddr=0x10 sampled at edge k, MemRData=0xDEADBEEF -> MemEN=1 and MemAddr=0x10 in cycles k+1..k+2, MemWE=0. IReady=1 in cycle k+3 with IRData=0xDEADBEEF.
- Contention: IReq and DReq both rise at edge k -> D is served first (DReady in k+3). The I access runs k+4..k+5 and IReady pulses in k+6.
- Starvation bound (MAX_DSTREAK=4): IReq held and DReq re-asserted continuously -> 4 D grants, then an I grant. dstreak returns to 0, and the next grant is D again.
- Write: DReq=1, DWE=1, DAddr=0x20, DWData=0x12345678 -> MemWE=1 for exactly 2 cycles with MemWData=0x12345678. DReady pulses at k+3, and DRData keeps its prior value.
- Reset mid-access: RESET=0 in cycle k+1 of a D write -> no DReady, MemEN=MemWE=0 from k+2. A held request is re-served after reset is released.
